// File: rtl/eth_rx_frame_fifo.sv
// rtl/eth_rx_frame_fifo.sv - store-and-forward Ethernet RX frame buffer
// Only frames ending with tuser=0 that fit the buffer become visible on the master stream.
module eth_rx_frame_fifo #(
    parameter int C_ADDR_W    = 11,
    parameter int C_IDLE_SYNC = 64
) (
    input  logic        rx_mac_aclk,
    input  logic        rx_mac_resetn,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] stat_good_frames,
    output logic [15:0] stat_bad_frames,
    output logic [15:0] stat_ovf_frames
);
    localparam int DEPTH = 1 << C_ADDR_W;

    typedef enum logic [1:0] {S_SYNC, S_ACCEPT, S_DROP} wr_state_e;

    wr_state_e             state_q, state_d;
    logic [15:0]           idle_cnt_q, idle_cnt_d;
    logic [16:0]           idle_next;
    logic [C_ADDR_W-1:0]   wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q, rd_ptr_d;
    logic [C_ADDR_W-1:0]   wr_ptr_inc;
    logic                  full, mem_we;
    logic [15:0]           good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;

    logic [8:0]            mem [DEPTH];
    logic [8:0]            ram_dout_q;
    logic                  ram_rd_en, ram_vld_q, ram_vld_d, out_ready;
    logic                  out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic [7:0]            out_data_q, out_data_d;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign wr_ptr_inc = wr_ptr_q + C_ADDR_W'(1);
    // A read in this cycle frees its slot only from the next cycle on.
    assign full       = (wr_ptr_inc == rd_ptr_q);
    assign idle_next  = {1'b0, idle_cnt_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        good_d      = good_q;
        bad_d       = bad_q;
        ovf_d       = ovf_q;
        mem_we      = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (s_axis_tvalid) begin
                    idle_cnt_d = '0;
                    if (s_axis_tlast) state_d = S_ACCEPT;
                end else begin
                    idle_cnt_d = idle_next[15:0];
                    if (idle_next >= 17'(C_IDLE_SYNC)) state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (s_axis_tvalid) begin
                    if (s_axis_tlast && s_axis_tuser) begin
                        wr_ptr_d = wr_commit_q;
                        bad_d    = sat_inc(bad_q);
                    end else if (full) begin
                        wr_ptr_d = wr_commit_q;
                        if (s_axis_tlast) ovf_d = sat_inc(ovf_q);
                        else              state_d = S_DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_inc;
                        if (s_axis_tlast) begin
                            wr_commit_d = wr_ptr_inc;
                            good_d      = sat_inc(good_q);
                        end
                    end
                end
            end
            S_DROP: begin
                if (s_axis_tvalid && s_axis_tlast) begin
                    ovf_d   = sat_inc(ovf_q);
                    state_d = S_ACCEPT;
                end
            end
            default: state_d = S_SYNC;
        endcase
    end

    // Two-stage read: RAM output register feeds the AXIS output register;
    // the RAM is re-read whenever its data word is empty or moving on.
    always_comb begin
        out_ready  = !out_vld_q || m_axis_tready;
        ram_rd_en  = (rd_ptr_q != wr_commit_q) && (!ram_vld_q || out_ready);
        rd_ptr_d   = ram_rd_en ? rd_ptr_q + C_ADDR_W'(1) : rd_ptr_q;
        ram_vld_d  = ram_rd_en || (ram_vld_q && !out_ready);
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_last_d = out_last_q;
        if (out_ready) begin
            out_vld_d = ram_vld_q;
            if (ram_vld_q) begin
                out_data_d = ram_dout_q[7:0];
                out_last_d = ram_dout_q[8];
            end
        end
    end

    always_ff @(posedge rx_mac_aclk) begin
        if (mem_we) mem[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
        if (ram_rd_en) ram_dout_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge rx_mac_aclk) begin
        if (!rx_mac_resetn) begin
            state_q     <= S_SYNC;
            idle_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            rd_ptr_q    <= '0;
            good_q      <= '0;
            bad_q       <= '0;
            ovf_q       <= '0;
            ram_vld_q   <= 1'b0;
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            rd_ptr_q    <= rd_ptr_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            ovf_q       <= ovf_d;
            ram_vld_q   <= ram_vld_d;
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign m_axis_tdata     = out_data_q;
    assign m_axis_tvalid    = out_vld_q;
    assign m_axis_tlast     = out_last_q;
    assign stat_good_frames = good_q;
    assign stat_bad_frames  = bad_q;
    assign stat_ovf_frames  = ovf_q;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// tb/tb_eth_rx_frame_fifo.sv - self-checking bench for eth_rx_frame_fifo
// Drives a default-size and a 64-deep instance from one MAC stream.
module tb_eth_rx_frame_fifo;
    localparam int AW_S = 6;
    localparam int IDLE = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  s_tdata;
    logic        s_tvalid, s_tlast, s_tuser;
    logic [7:0]  mb_tdata, ms_tdata;
    logic        mb_tvalid, ms_tvalid, mb_tlast, ms_tlast, mb_tready, ms_tready;
    logic [15:0] b_good, b_bad, b_ovf, s_good, s_bad, s_ovf;

    eth_rx_frame_fifo dut_b (
        .rx_mac_aclk(clk), .rx_mac_resetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(mb_tdata), .m_axis_tvalid(mb_tvalid), .m_axis_tready(mb_tready), .m_axis_tlast(mb_tlast),
        .stat_good_frames(b_good), .stat_bad_frames(b_bad), .stat_ovf_frames(b_ovf));

    eth_rx_frame_fifo #(.C_ADDR_W(AW_S)) dut_s (
        .rx_mac_aclk(clk), .rx_mac_resetn(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(ms_tdata), .m_axis_tvalid(ms_tvalid), .m_axis_tready(ms_tready), .m_axis_tlast(ms_tlast),
        .stat_good_frames(s_good), .stat_bad_frames(s_bad), .stat_ovf_frames(s_ovf));

    int tests_run = 0;
    int tests_failed = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_b[$];
    logic [8:0] got_s[$];
    logic [7:0] tx[$];
    bit         rnd_ready = 0;
    int         stab_err = 0;
    logic       pv = 0, pr = 0;
    logic [8:0] pd = '0;

    // Outputs sampled on the falling edge; inputs change 1 time unit after the rising edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (mb_tvalid && mb_tready) got_b.push_back({mb_tlast, mb_tdata});
            if (ms_tvalid && ms_tready) got_s.push_back({ms_tlast, ms_tdata});
            if (pv && !pr && !(mb_tvalid && {mb_tlast, mb_tdata} == pd)) stab_err++;
            pv = mb_tvalid;
            pr = mb_tready;
            pd = {mb_tlast, mb_tdata};
        end else begin
            pv = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rnd_ready) begin
            #1;
            mb_tready = 1'($urandom_range(0, 1));
        end
    end

    function automatic int qdiff(input logic [8:0] a[$], input logic [8:0] b[$]);
        int d = 0;
        if (a.size() != b.size()) return -1;
        foreach (a[i]) if (a[i] !== b[i]) d++;
        return d;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [7:0] d, input bit l, input bit u);
        s_tdata = d; s_tvalid = 1'b1; s_tlast = l; s_tuser = u;
        tick(1);
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    endtask

    task automatic make_frame(input int len, input bit rnd);
        tx.delete();
        for (int i = 0; i < len; i++) tx.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    task automatic send_tx(input int from, input int to, input bit u);
        for (int i = from; i < to; i++) beat(tx[i], i == tx.size() - 1, u);
    endtask

    task automatic expect_tx();
        foreach (tx[i]) exp_q.push_back({i == tx.size() - 1, tx[i]});
    endtask

    task automatic do_reset();
        rnd_ready = 0;
        rst_n = 1'b0; mb_tready = 1'b1; ms_tready = 1'b1;
        s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        tick(3);
        rst_n = 1'b1;
        exp_q.delete(); got_b.delete(); got_s.delete();
    endtask

    task automatic drain(input int n, input bit sm, input int budget);
        int c = 0;
        while ((sm ? got_s.size() : got_b.size()) < n && c < budget) begin
            tick(1);
            c++;
        end
        tick(8);
    endtask

    task automatic test_reset_and_basic();
        do_reset();
        tests_run++;
        if ({mb_tvalid, mb_tlast, mb_tdata} !== 10'h000) begin
            tests_failed++;
            $display("FAIL reset_out: got %h want 000", {mb_tvalid, mb_tlast, mb_tdata});
        end
        tests_run++;
        if ({b_good, b_bad, b_ovf} !== 48'h0) begin
            tests_failed++;
            $display("FAIL reset_stats: got %h want 0", {b_good, b_bad, b_ovf});
        end
        tick(IDLE + 6);
        make_frame(60, 0);
        expect_tx();
        send_tx(0, 60, 0);
        drain(60, 0, 500);
        tests_run++;
        if (qdiff(exp_q, got_b) != 0) begin
            tests_failed++;
            $display("FAIL basic_data: got %0d beats (diff %0d) want %0d", got_b.size(), qdiff(exp_q, got_b), exp_q.size());
        end
        tests_run++;
        if (b_good !== 16'd1) begin
            tests_failed++;
            $display("FAIL basic_good: got %0d want 1", b_good);
        end
    endtask

    task automatic test_bad_frame();
        do_reset();
        tick(IDLE + 6);
        make_frame(60, 1);
        send_tx(0, 60, 1);
        tick(3);
        make_frame(64, 1);
        expect_tx();
        send_tx(0, 64, 0);
        drain(64, 0, 500);
        tests_run++;
        if (qdiff(exp_q, got_b) != 0) begin
            tests_failed++;
            $display("FAIL bad_data: got %0d beats (diff %0d) want %0d", got_b.size(), qdiff(exp_q, got_b), exp_q.size());
        end
        tests_run++;
        if ({b_good, b_bad, b_ovf} !== {16'd1, 16'd1, 16'd0}) begin
            tests_failed++;
            $display("FAIL bad_stats: got %h want 000100010000", {b_good, b_bad, b_ovf});
        end
    endtask

    task automatic test_overflow();
        int committed = 0;
        int exp_good = 0;
        int exp_ovf = 0;
        do_reset();
        ms_tready = 1'b0;
        tick(IDLE + 6);
        for (int k = 0; k < 2; k++) begin
            make_frame(40, 1);
            if (committed + 40 <= (1 << AW_S) - 1) begin
                committed += 40;
                exp_good++;
                expect_tx();
            end else begin
                exp_ovf++;
            end
            send_tx(0, 40, 0);
            tick(2);
        end
        tick(10);
        tests_run++;
        if (s_ovf !== 16'(exp_ovf) || s_good !== 16'(exp_good)) begin
            tests_failed++;
            $display("FAIL ovf_stats: got good %0d ovf %0d want good %0d ovf %0d", s_good, s_ovf, exp_good, exp_ovf);
        end
        tests_run++;
        if (ms_tvalid !== 1'b1 || got_s.size() != 0) begin
            tests_failed++;
            $display("FAIL ovf_hold: got tvalid %b taken %0d want 1 0", ms_tvalid, got_s.size());
        end
        ms_tready = 1'b1;
        drain(exp_q.size(), 1, 500);
        tests_run++;
        if (qdiff(exp_q, got_s) != 0) begin
            tests_failed++;
            $display("FAIL ovf_data: got %0d beats (diff %0d) want %0d", got_s.size(), qdiff(exp_q, got_s), exp_q.size());
        end
    endtask

    task automatic test_depth_boundary();
        do_reset();
        tick(IDLE + 6);
        make_frame(1 << AW_S, 1);
        send_tx(0, 1 << AW_S, 0);
        tick(20);
        tests_run++;
        if (s_ovf !== 16'd1 || s_good !== 16'd0) begin
            tests_failed++;
            $display("FAIL depth_stats: got good %0d ovf %0d want 0 1", s_good, s_ovf);
        end
        tests_run++;
        if (ms_tvalid !== 1'b0 || got_s.size() != 0) begin
            tests_failed++;
            $display("FAIL depth_empty: got tvalid %b beats %0d want 0 0", ms_tvalid, got_s.size());
        end
        make_frame((1 << AW_S) - 1, 1);
        expect_tx();
        send_tx(0, (1 << AW_S) - 1, 0);
        drain(exp_q.size(), 1, 500);
        tests_run++;
        if (qdiff(exp_q, got_s) != 0 || s_good !== 16'd1) begin
            tests_failed++;
            $display("FAIL depth_fit: got %0d beats good %0d want %0d beats good 1", got_s.size(), s_good, exp_q.size());
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        tick(IDLE + 6);
        make_frame(60, 1);
        send_tx(0, 20, 0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        got_b.delete();
        tick(10);
        send_tx(20, 60, 0);
        tick(30);
        tests_run++;
        if (got_b.size() != 0 || {b_good, b_bad, b_ovf} !== 48'h0) begin
            tests_failed++;
            $display("FAIL midreset_none: got %0d beats stats %h want 0 0", got_b.size(), {b_good, b_bad, b_ovf});
        end
        tick(5);
        make_frame(50, 1);
        expect_tx();
        send_tx(0, 50, 0);
        drain(50, 0, 500);
        tests_run++;
        if (qdiff(exp_q, got_b) != 0 || b_good !== 16'd1) begin
            tests_failed++;
            $display("FAIL midreset_next: got %0d beats good %0d want %0d good 1", got_b.size(), b_good, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int lens[3] = '{46, 100, 1500};
        do_reset();
        tick(IDLE + 6);
        stab_err = 0;
        rnd_ready = 1;
        foreach (lens[k]) begin
            make_frame(lens[k], 1);
            expect_tx();
            send_tx(0, lens[k], 0);
        end
        drain(exp_q.size(), 0, 20000);
        rnd_ready = 0;
        tick(2);
        mb_tready = 1'b1;
        tests_run++;
        if (qdiff(exp_q, got_b) != 0) begin
            tests_failed++;
            $display("FAIL b2b_data: got %0d beats (diff %0d) want %0d", got_b.size(), qdiff(exp_q, got_b), exp_q.size());
        end
        tests_run++;
        if (b_good !== 16'd3) begin
            tests_failed++;
            $display("FAIL b2b_good: got %0d want 3", b_good);
        end
        tests_run++;
        if (stab_err != 0) begin
            tests_failed++;
            $display("FAIL b2b_stable: got %0d violations want 0", stab_err);
        end
    endtask

    initial begin
        test_reset_and_basic();
        test_bad_frame();
        test_overflow();
        test_depth_boundary();
        test_reset_midframe();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
